// File: rtl/mem_scan_ctrl.sv
// rtl/mem_scan_ctrl.sv - debounced push-button address scanner feeding a memory word to the display driver
module mem_scan_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int ADDR_W          = 5,
  parameter int DATA_W          = 32,
  parameter int MEM_DEPTH       = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              btn_next_s,
  input  logic              btn_prev_s,
  input  logic              sel_imem,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid,
  input  logic              disp_ready,
  output logic              scan_busy
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_READ = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  logic [1:0] btn_s;
  logic [1:0] press_p;

  assign btn_s = {btn_prev_s, btn_next_s};

  // Index 0 debounces "next", index 1 debounces "prev".
  for (genvar b = 0; b < 2; b++) begin : g_deb
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stable_q, stable_d;
    logic             press_q, press_d;

    always_comb begin
      cnt_d    = '0;
      stable_d = stable_q;
      press_d  = 1'b0;
      if (btn_s[b] != stable_q) begin
        if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          stable_d = btn_s[b];
          press_d  = btn_s[b];
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q    <= '0;
        stable_q <= 1'b0;
        press_q  <= 1'b0;
      end else begin
        cnt_q    <= cnt_d;
        stable_q <= stable_d;
        press_q  <= press_d;
      end
    end

    assign press_p[b] = press_q;
  end

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                sel_q, sel_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                valid_q, valid_d;
  logic [ADDR_W-1:0]   addr_inc, addr_dec;

  assign addr_inc = (addr_q == ADDR_W'(MEM_DEPTH - 1)) ? '0 : addr_q + ADDR_W'(1);
  assign addr_dec = (addr_q == '0) ? ADDR_W'(MEM_DEPTH - 1) : addr_q - ADDR_W'(1);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    sel_d   = sel_q;
    data_d  = data_q;
    valid_d = valid_q;
    unique case (state_q)
      S_IDLE: begin
        // A display-source change wins over any press landing in the same cycle.
        if (sel_imem != sel_q) begin
          sel_d   = sel_imem;
          state_d = S_ADDR;
        end else if (press_p[0] && !press_p[1]) begin
          addr_d  = addr_inc;
          state_d = S_ADDR;
        end else if (press_p[1] && !press_p[0]) begin
          addr_d  = addr_dec;
          state_d = S_ADDR;
        end
      end
      S_ADDR: state_d = S_READ;
      S_READ: begin
        data_d  = sel_q ? imem_rdata : dmem_rdata;
        valid_d = 1'b1;
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (disp_ready) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Reset lands in ADDR so word 0 is shown without any button activity.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_ADDR;
      addr_q  <= '0;
      sel_q   <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign mem_addr   = addr_q;
  assign disp_data  = data_q;
  assign disp_valid = valid_q;
  assign scan_busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_scan_ctrl.sv
// tb/tb_mem_scan_ctrl.sv - directed and randomized self-checking bench for mem_scan_ctrl
module tb_mem_scan_ctrl;

  localparam int DEPTH = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        btn_next_s = 1'b0;
  logic        btn_prev_s = 1'b0;
  logic        sel_imem = 1'b0;
  logic [4:0]  mem_addr;
  logic [31:0] imem_rdata = '0;
  logic [31:0] dmem_rdata = '0;
  logic [31:0] disp_data;
  logic        disp_valid;
  logic        disp_ready = 1'b0;
  logic        scan_busy;

  int checks = 0;
  int errors = 0;
  int xfers = 0;
  logic [31:0] last_data = '0;

  int          exp_addr;
  bit          exp_sel;
  int          exp_xfers;
  bit          held_ok;
  logic [31:0] held_data;

  mem_scan_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .ADDR_W(5),
    .DATA_W(32),
    .MEM_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_next_s(btn_next_s),
    .btn_prev_s(btn_prev_s),
    .sel_imem(sel_imem),
    .mem_addr(mem_addr),
    .imem_rdata(imem_rdata),
    .dmem_rdata(dmem_rdata),
    .disp_data(disp_data),
    .disp_valid(disp_valid),
    .disp_ready(disp_ready),
    .scan_busy(scan_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    imem_rdata <= 32'hA000_0000 + 32'(mem_addr);
    dmem_rdata <= 32'hD000_0000 + 32'(mem_addr);
    if (rst_n && disp_valid && disp_ready) begin
      xfers++;
      last_data = disp_data;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_word();
    return (exp_sel ? 32'hA000_0000 : 32'hD000_0000) + 32'(exp_addr);
  endfunction

  task automatic drive_btn(input bit nxt, input bit prv, input int hold);
    @(negedge clk);
    btn_next_s = nxt;
    btn_prev_s = prv;
    repeat (hold) @(negedge clk);
    btn_next_s = 1'b0;
    btn_prev_s = 1'b0;
    repeat (9) @(negedge clk);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_addr"}, 32'(mem_addr), 32'(exp_addr));
    chk({tag, "_xfers"}, 32'(xfers), 32'(exp_xfers));
    chk({tag, "_data"}, last_data, exp_word());
    chk({tag, "_busy"}, 32'(scan_busy), 32'd0);
  endtask

  task automatic press_next(input string tag);
    drive_btn(1'b1, 1'b0, 6);
    exp_addr = (exp_addr + 1) % DEPTH;
    exp_xfers++;
    check_idle(tag);
  endtask

  task automatic press_prev(input string tag);
    drive_btn(1'b0, 1'b1, 6);
    exp_addr = (exp_addr + DEPTH - 1) % DEPTH;
    exp_xfers++;
    check_idle(tag);
  endtask

  initial begin
    exp_addr = 0; exp_sel = 0; exp_xfers = 0;
    repeat (3) @(negedge clk);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_data", disp_data, 32'd0);
    chk("rst_valid", 32'(disp_valid), 32'd0);
    chk("rst_busy", 32'(scan_busy), 32'd1);

    // Automatic fetch of word 0 after reset release.
    disp_ready = 1'b1;
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    exp_xfers = 1;
    check_idle("boot");

    // Glitch shorter than the debounce window is ignored.
    drive_btn(1'b1, 1'b0, 2);
    check_idle("glitch");
    press_next("next1");

    // Wrap in both directions.
    press_prev("prev_to0");
    press_prev("prev_wrap");
    chk("prev_wrap_31", 32'(mem_addr), 32'd31);
    press_next("next_wrap");

    // Simultaneous presses cancel each other.
    drive_btn(1'b1, 1'b1, 6);
    check_idle("both");

    // Stall in HOLD, a press while busy is dropped.
    disp_ready = 1'b0;
    drive_btn(1'b1, 1'b0, 6);
    exp_addr = (exp_addr + 1) % DEPTH;
    chk("hold_valid", 32'(disp_valid), 32'd1);
    chk("hold_data", disp_data, exp_word());
    held_data = disp_data;
    held_ok = 1'b1;
    @(negedge clk);
    btn_next_s = 1'b1;
    for (int i = 0; i < 15; i++) begin
      if (i == 6) btn_next_s = 1'b0;
      @(negedge clk);
      if (!disp_valid || disp_data !== held_data) held_ok = 1'b0;
    end
    chk("hold_stable", 32'(held_ok), 32'd1);
    chk("hold_addr", 32'(mem_addr), 32'(exp_addr));
    disp_ready = 1'b1;
    repeat (3) @(negedge clk);
    exp_xfers++;
    check_idle("hold_release");

    // Randomized presses, glitches and source toggles against the model.
    for (int n = 0; n < 24; n++) begin
      int op;
      op = int'($urandom_range(0, 3));
      case (op)
        0: press_next("rnd_next");
        1: press_prev("rnd_prev");
        2: begin
          drive_btn($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                    int'($urandom_range(1, 3)));
          check_idle("rnd_glitch");
        end
        default: begin
          @(negedge clk);
          sel_imem = ~sel_imem;
          exp_sel = sel_imem;
          exp_xfers++;
          repeat (8) @(negedge clk);
          check_idle("rnd_sel");
        end
      endcase
    end

    // Move to address 5 on the data memory, then switch to instruction memory.
    if (exp_sel) begin
      @(negedge clk);
      sel_imem = 1'b0; exp_sel = 0; exp_xfers++;
      repeat (8) @(negedge clk);
    end
    while (exp_addr != 5) begin
      if (exp_addr < 5) press_next("to5_next");
      else press_prev("to5_prev");
    end
    @(negedge clk);
    sel_imem = 1'b1; exp_sel = 1; exp_xfers++;
    repeat (8) @(negedge clk);
    check_idle("sel_imem5");
    chk("sel_imem5_word", last_data, 32'hA000_0005);

    // Reset while stalled in HOLD.
    disp_ready = 1'b0;
    sel_imem = 1'b0; exp_sel = 0;
    repeat (8) @(negedge clk);
    chk("hold2_valid", 32'(disp_valid), 32'd1);
    chk("hold2_data", disp_data, 32'hD000_0005);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(disp_valid), 32'd0);
    chk("mid_rst_addr", 32'(mem_addr), 32'd0);
    chk("mid_rst_busy", 32'(scan_busy), 32'd1);
    repeat (2) @(negedge clk);
    disp_ready = 1'b1;
    rst_n = 1'b1;
    exp_addr = 0;
    exp_xfers++;
    repeat (10) @(negedge clk);
    check_idle("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
